// File: rtl/mem_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_ctrl_pkg
// Purpose  : Shared widths, FSM encoding and IO-address decode for mem_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_ctrl_pkg;

  localparam int ADDR_WID   = 32;
  localparam int DATA_WID   = 32;
  localparam int ST_LEN_WID = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  // IO space lives where address bits 17:16 are both set.
  function automatic logic is_io_addr(input logic [ADDR_WID-1:0] a);
    return a[17:16] == 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mem_ctrl
// Purpose  : Serialises LSB loads/stores and instruction fetches onto a
//            byte-wide synchronous RAM/IO bus; LSB wins over fetch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  call_valid,
  input  logic                  call_is_store,
  input  logic [ADDR_WID-1:0]   call_addr,
  input  logic [ST_LEN_WID-1:0] call_len,
  input  logic [DATA_WID-1:0]   call_data,
  output logic                  respond_valid,
  output logic [DATA_WID-1:0]   respond_data,
  input  logic                  if_valid,
  input  logic [ADDR_WID-1:0]   if_addr,
  output logic                  if_done,
  output logic [DATA_WID-1:0]   if_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WID-1:0]   mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  logic [1:0]            r_state;
  logic [ADDR_WID-1:0]   r_addr;
  logic [ST_LEN_WID-1:0] r_len;
  logic [ST_LEN_WID-1:0] r_ic;
  logic [ST_LEN_WID-1:0] r_cc;
  logic [DATA_WID-1:0]   r_data;
  logic [DATA_WID-1:0]   r_buf;
  // Read pipeline: r_issued = mem_a carries a read this cycle,
  // r_cap = mem_din carries the byte for that read this cycle.
  logic                  r_issued;
  logic                  r_cap;

  logic [ADDR_WID-1:0]   w_issue_addr;
  logic [7:0]            w_dout_byte;
  logic [DATA_WID-1:0]   w_buf_cap;
  logic                  w_last_cap;
  logic                  w_can_accept;

  always_comb begin
    w_issue_addr = r_addr + ADDR_WID'(r_ic);
    w_dout_byte  = r_data[{r_ic[1:0], 3'b000} +: 8];
    w_buf_cap    = r_buf;
    w_buf_cap[{r_cc[1:0], 3'b000} +: 8] = mem_din;
    w_last_cap   = (r_cc == r_len - ST_LEN_WID'(1));
    // A request still visible during a done pulse has already been served.
    w_can_accept = !rollback && !respond_valid && !if_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_ic          <= '0;
      r_cc          <= '0;
      r_data        <= '0;
      r_buf         <= '0;
      r_issued      <= 1'b0;
      r_cap         <= 1'b0;
      respond_valid <= 1'b0;
      respond_data  <= '0;
      if_done       <= 1'b0;
      if_data       <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr        <= 1'b0;
    end else if (rdy) begin
      respond_valid <= 1'b0;
      if_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          mem_a  <= '0;
          mem_wr <= 1'b0;
          if (w_can_accept && (call_valid || if_valid)) begin
            r_buf    <= '0;
            r_cc     <= '0;
            r_cap    <= 1'b0;
            r_issued <= 1'b0;
            r_ic     <= '0;
            if (call_valid) begin
              r_addr <= call_addr;
              r_len  <= call_len;
              r_data <= call_data;
              if (call_is_store) begin
                r_state <= ST_STORE;
                if (!(is_io_addr(call_addr) && io_buffer_full)) begin
                  mem_a    <= call_addr;
                  mem_wr   <= 1'b1;
                  mem_dout <= call_data[7:0];
                  r_ic     <= ST_LEN_WID'(1);
                end
              end else begin
                r_state  <= ST_LOAD;
                mem_a    <= call_addr;
                r_ic     <= ST_LEN_WID'(1);
                r_issued <= 1'b1;
              end
            end else begin
              r_state  <= ST_FETCH;
              r_addr   <= if_addr;
              r_len    <= ST_LEN_WID'(4);
              r_data   <= '0;
              mem_a    <= if_addr;
              r_ic     <= ST_LEN_WID'(1);
              r_issued <= 1'b1;
            end
          end
        end

        ST_STORE: begin
          if (r_ic == r_len) begin
            mem_a         <= '0;
            mem_wr        <= 1'b0;
            respond_valid <= 1'b1;
            r_ic          <= '0;
            r_state       <= ST_IDLE;
          end else if (is_io_addr(w_issue_addr) && io_buffer_full) begin
            mem_a  <= '0;
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= w_issue_addr;
            mem_wr   <= 1'b1;
            mem_dout <= w_dout_byte;
            r_ic     <= r_ic + ST_LEN_WID'(1);
          end
        end

        default: begin
          mem_wr <= 1'b0;
          if (rollback) begin
            r_state  <= ST_IDLE;
            mem_a    <= '0;
            r_ic     <= '0;
            r_cc     <= '0;
            r_buf    <= '0;
            r_issued <= 1'b0;
            r_cap    <= 1'b0;
          end else begin
            r_cap <= r_issued;
            if (r_ic != r_len) begin
              mem_a    <= w_issue_addr;
              r_ic     <= r_ic + ST_LEN_WID'(1);
              r_issued <= 1'b1;
            end else begin
              mem_a    <= '0;
              r_issued <= 1'b0;
            end
            if (r_cap) begin
              r_buf <= w_buf_cap;
              r_cc  <= r_cc + ST_LEN_WID'(1);
              if (w_last_cap) begin
                r_state  <= ST_IDLE;
                r_ic     <= '0;
                r_cc     <= '0;
                r_cap    <= 1'b0;
                r_issued <= 1'b0;
                if (r_state == ST_LOAD) begin
                  respond_valid <= 1'b1;
                  respond_data  <= w_buf_cap;
                end else begin
                  if_done <= 1'b1;
                  if_data <= w_buf_cap;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl with a byte-array memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        call_valid, call_is_store, if_valid, io_buffer_full;
  logic [31:0] call_addr, call_data, if_addr;
  logic [2:0]  call_len;
  logic        respond_valid, if_done, mem_wr;
  logic [31:0] respond_data, if_data, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:262143];
  logic [7:0]  model [0:1023];
  logic        pl_we;
  logic [17:0] pl_a;
  logic [7:0]  pl_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .call_valid(call_valid), .call_is_store(call_is_store),
    .call_addr(call_addr), .call_len(call_len), .call_data(call_data),
    .respond_valid(respond_valid), .respond_data(respond_data),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Synchronous RAM gated by rdy; preload port used only while the DUT is idle.
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (rdy && mem_wr) ram[mem_a[17:0]] <= mem_dout;
    if (rdy) mem_din <= ram[mem_a[17:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = model[int'(a) + i];
    return w;
  endfunction

  // kind: 0 load, 1 store, 2 fetch. Request presented in cycle 0; pulse cycle
  // must equal exp_lat. rb_cyc asserts rollback in that cycle; frz_cyc drops
  // rdy for two cycles starting there (per-cycle bus checks skipped then).
  task automatic txn(input string tag, input int kind, input logic [31:0] addr,
                     input int n, input logic [31:0] data, input int exp_lat,
                     input int rb_cyc, input int frz_cyc);
    int k, pulse_at;
    logic [31:0] got, exp_d;
    exp_d = (kind == 1) ? 32'h0 : model_word(addr, n);
    got = '0;
    if (kind == 2) begin
      if_valid = 1'b1; if_addr = addr;
    end else begin
      call_valid = 1'b1; call_is_store = (kind == 1); call_addr = addr;
      call_len = 3'(n); call_data = data;
    end
    pulse_at = -1;
    k = 0;
    while (pulse_at < 0 && k < 40) begin
      tick();
      k++;
      rollback = (k == rb_cyc);
      rdy = !(frz_cyc >= 0 && (k == frz_cyc || k == frz_cyc + 1));
      if (frz_cyc < 0 && k <= n) begin
        chk({tag, "_a"}, mem_a, addr + 32'(k - 1));
        chk({tag, "_wr"}, {31'b0, mem_wr}, {31'b0, kind == 1});
        if (kind == 1) chk({tag, "_dout"}, {24'b0, mem_dout}, {24'b0, data[8*(k-1) +: 8]});
      end
      if ((kind == 2) ? if_done : respond_valid) begin
        pulse_at = k;
        got = (kind == 2) ? if_data : respond_data;
      end
    end
    call_valid = 1'b0; if_valid = 1'b0; rollback = 1'b0; rdy = 1'b1;
    chk({tag, "_lat"}, 32'(pulse_at), 32'(exp_lat));
    if (kind != 1) chk({tag, "_data"}, got, exp_d);
    if (kind == 1 && addr < 32'd1020)
      for (int i = 0; i < n; i++) model[int'(addr) + i] = data[8*i +: 8];
    tick();
  endtask

  initial begin
    int rv_at, ifd_at, first_wr, pulses, kind, n;
    logic [31:0] a, d, rv_d, ifd_d;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; call_valid = 1'b0; call_is_store = 1'b0;
    call_addr = '0; call_len = '0; call_data = '0; if_valid = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    tick(); tick();
    chk("rst_rv", {31'b0, respond_valid}, 32'h0);
    chk("rst_rd", respond_data, 32'h0);
    chk("rst_ifd", {31'b0, if_done}, 32'h0);
    chk("rst_ifdata", if_data, 32'h0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_wr", {31'b0, mem_wr}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 1024; i++) begin
      pl_we = 1'b1; pl_a = 18'(i);
      case (i)
        32'h100: pl_d = 8'h11;
        32'h101: pl_d = 8'h22;
        32'h102: pl_d = 8'h33;
        32'h103: pl_d = 8'h44;
        default: pl_d = 8'($urandom);
      endcase
      model[i] = pl_d;
      tick();
    end
    pl_we = 1'b0;
    tick();

    txn("lw100", 0, 32'h100, 4, 32'h0, 6, -1, -1);
    chk("lw100_word", respond_data, 32'h44332211);
    txn("lb", 0, 32'h101, 1, 32'h0, 3, -1, -1);
    txn("lh", 0, 32'h102, 2, 32'h0, 4, -1, -1);
    txn("sh200", 1, 32'h200, 2, 32'hAABBCCDD, 3, -1, -1);
    txn("lh200", 0, 32'h200, 2, 32'h0, 4, -1, -1);
    chk("lh200_word", respond_data, 32'h0000CCDD);
    txn("fetch", 2, 32'h104, 4, 32'h0, 6, -1, -1);

    // IO store held off by a full buffer in cycles 0..2
    io_buffer_full = 1'b1;
    call_valid = 1'b1; call_is_store = 1'b1; call_addr = 32'h30000; call_len = 3'd1;
    call_data = 32'h0000005A;
    first_wr = -1; rv_at = -1;
    for (int k = 1; k <= 12 && rv_at < 0; k++) begin
      tick();
      if (k == 3) io_buffer_full = 1'b0;
      if (mem_wr && first_wr < 0) begin
        first_wr = k;
        chk("io_a", mem_a, 32'h30000);
        chk("io_dout", {24'b0, mem_dout}, 32'h5A);
      end
      if (respond_valid) rv_at = k;
    end
    call_valid = 1'b0;
    chk("io_first_wr", 32'(first_wr), 32'd4);
    chk("io_lat", 32'(rv_at), 32'd5);
    tick();

    // Load and fetch raised together: load first, fetch after the pulse
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h300; call_len = 3'd4;
    if_valid = 1'b1; if_addr = 32'h40;
    rv_at = -1; ifd_at = -1; rv_d = '0; ifd_d = '0;
    for (int k = 1; k <= 40 && ifd_at < 0; k++) begin
      tick();
      if (respond_valid) begin rv_at = k; rv_d = respond_data; call_valid = 1'b0; end
      if (if_done) begin ifd_at = k; ifd_d = if_data; if_valid = 1'b0; end
    end
    call_valid = 1'b0; if_valid = 1'b0;
    chk("arb_lw_lat", 32'(rv_at), 32'd6);
    chk("arb_lw_data", rv_d, model_word(32'h300, 4));
    chk("arb_if_lat", 32'(ifd_at), 32'd13);
    chk("arb_if_data", ifd_d, model_word(32'h40, 4));
    tick();

    // Rollback during a load: bus idle next cycle, no pulse ever
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h104; call_len = 3'd4;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      rollback = (k == 3);
      if (k == 3) call_valid = 1'b0;
      if (k == 4) chk("rb_idle_a", mem_a, 32'h0);
      if (respond_valid) pulses++;
    end
    rollback = 1'b0;
    chk("rb_no_pulse", 32'(pulses), 32'd0);

    txn("sw_rb", 1, 32'h208, 4, 32'h87654321, 5, 2, -1);
    txn("lw208", 0, 32'h208, 4, 32'h0, 6, -1, -1);
    chk("lw208_word", respond_data, 32'h87654321);

    // Reset in cycle 2 of a load
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h10; call_len = 3'd4;
    tick(); tick();
    rst = 1'b1; call_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mrst_rv", {31'b0, respond_valid}, 32'h0);
    chk("mrst_rd", respond_data, 32'h0);
    chk("mrst_ifdata", if_data, 32'h0);
    chk("mrst_a", mem_a, 32'h0);
    chk("mrst_dout", {24'b0, mem_dout}, 32'h0);
    chk("mrst_wr", {31'b0, mem_wr}, 32'h0);
    txn("lb_after_rst", 0, 32'h103, 1, 32'h0, 3, -1, -1);
    chk("lb_after_rst_word", respond_data, 32'h00000044);

    txn("lw_frz", 0, 32'h10C, 4, 32'h0, 8, -1, 2);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      n = (kind == 2) ? 4 : (1 << $urandom_range(0, 2));
      a = 32'($urandom_range(0, 1019));
      d = $urandom;
      if (kind == 1)
        txn("rnd_st", 1, a, n, d, n + 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1, -1);
      else
        txn((kind == 2) ? "rnd_if" : "rnd_ld", kind, a, n, 32'h0, n + 2, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
